ct_ifu_spsram_1024x64_ctrl: RTL and testbench



---
 rtl/ct_ifu_spsram_1024x64_ctrl.sv | 126 ++++++++++++
 tb/tb_ct_ifu_spsram_1024x64_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_spsram_1024x64_ctrl.sv
// Access controller for the 1024x64 single-port IFU SRAM macro.
// Arbitrates refill writes against fetch reads and drives the macro's
// active-low CEN/GWEN/WEN controls. Clears every entry after reset and on
// invalidate-all. Read data is presented one cycle after the grant and then
// held until the next read returns.
module ct_ifu_spsram_1024x64_ctrl #(
   parameter int                    ADDR_WIDTH = 10,
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  inv_all_req,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_grant,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_bmask,
   output logic                  wr_grant,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  init_busy,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   localparam logic [1:0] RST_WAIT = 2'd0;
   localparam logic [1:0] INIT     = 2'd1;
   localparam logic [1:0] READY    = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] hold;

   // Next-state and sweep counter: counter only wraps when leaving INIT.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RST_WAIT: begin
            state_nxt = INIT;
            cnt_nxt   = '0;
         end
         INIT: begin
            if (inv_all_req) begin
               cnt_nxt = '0;
            end else if (&cnt) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         READY: begin
            if (inv_all_req) begin
               state_nxt = INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = RST_WAIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Macro controls and grants; priority inv_all_req > write > read.
   always_comb begin
      rd_grant  = 1'b0;
      wr_grant  = 1'b0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (state == INIT) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = cnt;
         sram_d    = INIT_VAL;
      end else if (state == READY && !inv_all_req) begin
         if (wr_req) begin
            wr_grant  = 1'b1;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~wr_bmask;
            sram_a    = wr_addr;
            sram_d    = wr_data;
         end else if (rd_req) begin
            rd_grant  = 1'b1;
            sram_cen  = 1'b0;
            sram_a    = rd_addr;
         end
      end
   end

   // State, counter, read-pending flag and read hold register.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state   <= RST_WAIT;
         cnt     <= '0;
         rd_pend <= 1'b0;
         hold    <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rd_pend <= rd_grant;
         if (rd_pend) hold <= sram_q;
      end
   end

   assign init_busy = (state != READY);
   assign rd_vld    = rd_pend;
   assign rd_data   = rd_pend ? sram_q : hold;

endmodule

// File: tb/tb_ct_ifu_spsram_1024x64_ctrl.sv
// Scoreboard bench for ct_ifu_spsram_1024x64_ctrl with a behavioural macro.
module tb_ct_ifu_spsram_1024x64_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inv_all_req = 1'b0;
   logic        rd_req = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic        rd_grant;
   logic        wr_req = 1'b0;
   logic [9:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic [63:0] wr_bmask = '0;
   logic        wr_grant;
   logic        rd_vld;
   logic [63:0] rd_data;
   logic        init_busy;
   logic [9:0]  sram_a;
   logic        sram_cen;
   logic        sram_gwen;
   logic [63:0] sram_wen;
   logic [63:0] sram_d;
   logic [63:0] sram_q = '0;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mem [1024];

   ct_ifu_spsram_1024x64_ctrl dut (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .inv_all_req(inv_all_req),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_bmask(wr_bmask), .wr_grant(wr_grant), .rd_vld(rd_vld),
      .rd_data(rd_data), .init_busy(init_busy), .sram_a(sram_a),
      .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
      .sram_d(sram_d), .sram_q(sram_q)
   );

   always #5 clk = ~clk;

   // Behavioural single-port macro: active-low enables, per-bit write mask.
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q      <= mem[sram_a];
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor: every rd_vld pops the oldest expected read.
   always @(negedge clk) begin
      if (rst_n && rd_vld) begin
         if (exp_q.size() == 0) check("rd_vld_unexpected", 64'd1, 64'd0);
         else check("rd_data", rd_data, exp_q.pop_front());
      end
   end

   // Checks one full sweep starting at a negedge with state INIT, counter 0.
   task automatic sweep_check(input string nm);
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (!(sram_cen == 1'b0 && sram_gwen == 1'b0 && sram_wen == 64'h0 &&
               sram_a == 10'(i) && sram_d == 64'h0 && init_busy == 1'b1 &&
               rd_grant == 1'b0 && wr_grant == 1'b0)) bad++;
         @(negedge clk);
      end
      check({nm, "_bad_cycles"}, 64'(bad), 64'd0);
      check({nm, "_busy_done"}, {63'd0, init_busy}, 64'd0);
   endtask

   task automatic do_write(input string nm, input logic [9:0] a, input logic [63:0] d,
                           input logic [63:0] m, input logic [63:0] exp_wen);
      int n = 0;
      wr_req = 1'b1; wr_addr = a; wr_data = d; wr_bmask = m;
      #1;
      while (!wr_grant && n < 8) begin @(negedge clk); #1; n++; end
      check({nm, "_grant"}, {63'd0, wr_grant}, 64'd1);
      check({nm, "_wen"}, sram_wen, exp_wen);
      check({nm, "_a_cen"}, {sram_a, sram_cen, sram_gwen}, {a, 1'b0, 1'b0});
      @(negedge clk);
      wr_req = 1'b0;
   endtask

   task automatic do_read(input string nm, input logic [9:0] a, input logic [63:0] exp);
      int n = 0;
      rd_req = 1'b1; rd_addr = a;
      #1;
      while (!rd_grant && n < 8) begin @(negedge clk); #1; n++; end
      check({nm, "_grant"}, {63'd0, rd_grant}, 64'd1);
      if (rd_grant) exp_q.push_back(exp);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   initial begin
      // Reset values while reset is held.
      #12;
      check("rst_grants_vld", {61'd0, rd_grant, wr_grant, rd_vld}, 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_ctrl", {53'd0, init_busy, sram_cen, sram_gwen, sram_a}, {53'd0, 3'b111, 10'd0});
      check("rst_wen", sram_wen, '1);
      check("rst_d", sram_d, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_wait_cen", {63'd0, sram_cen}, 64'd1);
      @(negedge clk);
      sweep_check("sweep0");

      // Full-mask write then read back, data held after rd_vld drops.
      do_write("wr5", 10'd5, 64'hDEADBEEF_CAFEF00D, '1, 64'h0);
      do_read("rd5", 10'd5, 64'hDEADBEEF_CAFEF00D);
      check("rd5_vld", {63'd0, rd_vld}, 64'd1);
      @(negedge clk);
      check("rd5_vld_drop", {63'd0, rd_vld}, 64'd0);
      check("rd5_hold", rd_data, 64'hDEADBEEF_CAFEF00D);

      // Partial write.
      do_write("pwr5", 10'd5, '1, 64'h0000_0000_FFFF_0000, 64'hFFFF_FFFF_0000_FFFF);
      do_read("prd5", 10'd5, 64'hDEADBEEF_FFFFF00D);
      @(negedge clk);

      // Simultaneous read and write to the same address: write wins.
      rd_req = 1'b1; rd_addr = 10'd7;
      wr_req = 1'b1; wr_addr = 10'd7; wr_data = 64'h0123_4567_89AB_CDEF; wr_bmask = '1;
      #1;
      check("sim_wr_grant", {62'd0, wr_grant, rd_grant}, 64'd2);
      @(negedge clk);
      wr_req = 1'b0;
      #1;
      check("sim_rd_grant", {62'd0, wr_grant, rd_grant}, 64'd1);
      exp_q.push_back(64'h0123_4567_89AB_CDEF);
      @(negedge clk);
      rd_req = 1'b0;

      // Zero-mask write still occupies the macro but changes nothing.
      do_write("zwr7", 10'd7, 64'h0, 64'h0, '1);

      // Back-to-back reads keep rd_vld high.
      rd_req = 1'b1; rd_addr = 10'd5;
      #1; check("b2b_g0", {63'd0, rd_grant}, 64'd1);
      exp_q.push_back(64'hDEADBEEF_FFFFF00D);
      @(negedge clk);
      rd_addr = 10'd7;
      #1; check("b2b_g1", {63'd0, rd_grant}, 64'd1);
      exp_q.push_back(64'h0123_4567_89AB_CDEF);
      @(negedge clk);
      check("b2b_vld", {63'd0, rd_vld}, 64'd1);

      // Invalidate right after a read grant, with rd_req still high.
      inv_all_req = 1'b1; rd_addr = 10'd5;
      #1;
      check("inv_no_grant", {62'd0, rd_grant, wr_grant}, 64'd0);
      check("inv_keeps_vld", {63'd0, rd_vld}, 64'd1);
      @(negedge clk);
      inv_all_req = 1'b0; rd_req = 1'b0;
      sweep_check("sweep_inv");
      do_read("rd5_clr", 10'd5, 64'h0);
      @(negedge clk);

      // Reset in the middle of a sweep restarts it from 0.
      inv_all_req = 1'b1;
      @(negedge clk);
      inv_all_req = 1'b0;
      repeat (300) @(negedge clk);
      check("mid_a", {54'd0, sram_a}, 64'd300);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ctrl", {61'd0, sram_cen, sram_gwen, init_busy}, 64'd7);
      check("mid_rst_data", rd_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mid_wait_cen", {63'd0, sram_cen}, 64'd1);
      @(negedge clk);
      sweep_check("sweep_rst");
      do_read("rd7_clr", 10'd7, 64'h0);
      @(negedge clk);
      @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
